// File: rtl/p4_adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p4_arb_pkg
// Description : Shared types for the P4 adder round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package p4_arb_pkg;

    // Scheduler phases: wait for a request, let the adder settle, hold result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index following idx, wrapping back to zero after the last requester.
    function automatic int next_index(input int idx, input int nreq);
        return (idx == nreq - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/p4_adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : p4_adder_arbiter_if
// Description : Request/response channels between the clients and the
//               shared P4 adder scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface p4_adder_arbiter_if #(
    parameter int NBIT = 16,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NBIT-1:0] req_a;
    logic [NREQ*NBIT-1:0] req_b;
    logic [NREQ-1:0]      req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [NBIT-1:0]      rsp_s;
    logic                 rsp_cout;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout
    );
endinterface
`default_nettype wire

// File: rtl/p4_adder_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               after ptr, searching upward modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req,
    input  wire logic [IDW-1:0]  ptr,
    output logic      [NREQ-1:0] grant,
    output logic      [IDW-1:0]  gidx,
    output logic                 any_req
);

    int w_idx;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        any_req = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!any_req && req[w_idx]) begin
                any_req      = 1'b1;
                grant[w_idx] = 1'b1;
                gidx         = IDW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/p4_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : p4_adder_arbiter
// Description : Shares one external combinational P4 adder among NREQ
//               requesters; registered operands in, registered result out,
//               response tagged with the owning requester index.
// Revision    : 1.0 - initial release
// ============================================================================
module p4_adder_arbiter
    import p4_arb_pkg::*;
#(
    parameter int NBIT = 16,
    parameter int NREQ = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    p4_adder_arbiter_if.slave     bus,
    output logic      [NBIT-1:0]  add_a,
    output logic      [NBIT-1:0]  add_b,
    output logic                  add_cin,
    input  wire logic [NBIT-1:0]  add_s,
    input  wire logic             add_cout
);

    localparam int IDW = $clog2(NREQ);

    state_t            r_state;
    state_t            w_next;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [NBIT-1:0]   r_a;
    logic [NBIT-1:0]   r_b;
    logic              r_cin;
    logic [NBIT-1:0]   r_s;
    logic              r_cout;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_gidx;
    logic              w_any;
    logic [NREQ-1:0]   w_req_ready;
    logic              w_accept;
    logic              w_rsp_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .gidx    (w_gidx),
        .any_req (w_any)
    );

    // Next-state and handshake decode; ready only ever asserted in IDLE.
    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_accept    = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_req_ready = w_grant;
                    w_accept    = 1'b1;
                    w_next      = CALC;
                end
            end
            CALC: w_next = RESP;
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture on accept, result capture after the adder settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_cin  <= 1'b0;
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.req_a[w_gidx*NBIT +: NBIT];
                r_b   <= bus.req_b[w_gidx*NBIT +: NBIT];
                r_cin <= bus.req_cin[w_gidx];
                r_id  <= w_gidx;
                r_ptr <= IDW'(next_index(int'(w_gidx), NREQ));
            end
            if (r_state == CALC) begin
                r_s    <= add_s;
                r_cout <= add_cout;
            end
        end
    end

    // Ready is forced low while reset is held, even if clients are valid.
    assign bus.req_ready = rst_n ? w_req_ready : '0;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_s     = r_s;
    assign bus.rsp_cout  = r_cout;
    assign add_a         = r_a;
    assign add_b         = r_b;
    assign add_cin       = r_cin;

endmodule
`default_nettype wire

// File: tb/tb_p4_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_p4_adder_arbiter
// Description : Self-checking bench for the P4 adder round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p4_adder_arbiter;

    localparam int NBIT = 16;
    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NBIT-1:0] add_a, add_b, add_s;
    logic            add_cin, add_cout;

    p4_adder_arbiter_if #(.NBIT(NBIT), .NREQ(NREQ)) bus ();

    p4_adder_arbiter #(.NBIT(NBIT), .NREQ(NREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Stand-in for the external P4 adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{NBIT{1'b0}}, add_cin};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what each client is presenting and the pointer.
    logic [NBIT-1:0] m_a [NREQ];
    logic [NBIT-1:0] m_b [NREQ];
    logic            m_cin [NREQ];
    int              m_ptr;

    typedef struct {
        int              id;
        logic [NBIT-1:0] a;
        logic [NBIT-1:0] b;
        logic            cin;
        int              stall;
        logic [NBIT-1:0] exp_s;
        logic            exp_cout;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [NBIT-1:0] a,
                           input logic [NBIT-1:0] b, input logic cin);
        bus.req_valid[i]           = 1'b1;
        bus.req_a[i*NBIT +: NBIT]  = a;
        bus.req_b[i*NBIT +: NBIT]  = b;
        bus.req_cin[i]             = cin;
        m_a[i]   = a;
        m_b[i]   = b;
        m_cin[i] = cin;
    endtask

    // One full transaction starting at an IDLE negedge with requests present.
    task automatic serve(input int stall, output int gid,
                         output logic [NBIT-1:0] s, output logic c);
        int              g;
        logic [NBIT:0]   sum;
        logic [NBIT-1:0] ea, eb;
        logic            ecin;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        if (g < 0) begin
            chk("no_pending_request", 32'd0, 32'd1);
            g = 0;
        end
        gid  = g;
        ea   = m_a[g];
        eb   = m_b[g];
        ecin = m_cin[g];
        sum  = {1'b0, ea} + {1'b0, eb} + {{NBIT{1'b0}}, ecin};
        #1;
        chk("req_ready_grant", 32'(bus.req_ready), 32'(1 << g));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[g] = 1'b0;
        m_ptr = (g + 1) % NREQ;
        chk("calc_req_ready", 32'(bus.req_ready), 32'd0);
        chk("calc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("calc_add_a", 32'(add_a), 32'(ea));
        chk("calc_add_b", 32'(add_b), 32'(eb));
        chk("calc_add_cin", 32'(add_cin), 32'(ecin));
        @(posedge clk);
        @(negedge clk);
        s = bus.rsp_s;
        c = bus.rsp_cout;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        chk("rsp_s", 32'(bus.rsp_s), 32'(sum[NBIT-1:0]));
        chk("rsp_cout", 32'(bus.rsp_cout), 32'(sum[NBIT]));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_id", 32'(bus.rsp_id), 32'(g));
            chk("stall_rsp_s", 32'(bus.rsp_s), 32'(sum[NBIT-1:0]));
            chk("stall_rsp_cout", 32'(bus.rsp_cout), 32'(sum[NBIT]));
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_add_a", 32'(add_a), 32'(ea));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_add_a_held", 32'(add_a), 32'(ea));
    endtask

    initial begin
        int              gid;
        logic [NBIT-1:0] s;
        logic            c;
        logic [NBIT-1:0] ra, rb;

        tbl[0] = '{2, 16'h1234, 16'h0001, 1'b1, 5, 16'h1236, 1'b0};
        tbl[1] = '{0, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1};
        tbl[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 1, 16'hFFFF, 1'b1};
        tbl[3] = '{3, 16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0};

        for (int i = 0; i < NREQ; i++) begin
            m_a[i] = '0; m_b[i] = '0; m_cin[i] = 1'b0;
        end
        m_ptr         = 0;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1010;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, with clients asserting valid to prove ready stays low.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_rsp_s", 32'(bus.rsp_s), 32'd0);
        chk("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int i = 0; i < 4; i++) begin
            set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin);
            serve(tbl[i].stall, gid, s, c);
            chk("tbl_id", 32'(gid), 32'(tbl[i].id));
            chk("tbl_s", 32'(s), 32'(tbl[i].exp_s));
            chk("tbl_cout", 32'(c), 32'(tbl[i].exp_cout));
        end

        // Sustained all-valid load, pointer starts at 0.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i]) set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
            end
            serve(0, gid, s, c);
            chk("rr_order", 32'(gid), 32'(r % NREQ));
        end
        bus.req_valid = '0;

        // Reset while a transaction is in CALC.
        set_req(1, 16'h00AA, 16'h0055, 1'b1);
        #1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        set_req(2, 16'h1111, 16'h2222, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("midrst_rsp_s", 32'(bus.rsp_s), 32'd0);
        chk("midrst_add_a", 32'(add_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        set_req(0, 16'h0100, 16'h0200, 1'b0);
        serve(0, gid, s, c);
        chk("after_rst_grant", 32'(gid), 32'd0);
        bus.req_valid = '0;

        // Only requester 3 valid with pointer at 1: must wrap back to 0.
        set_req(3, 16'h7FFF, 16'h0001, 1'b0);
        serve(0, gid, s, c);
        chk("wrap_grant", 32'(gid), 32'd3);
        set_req(1, 16'h0003, 16'h0004, 1'b0);
        set_req(0, 16'h0001, 16'h0002, 1'b1);
        serve(0, gid, s, c);
        chk("wrap_next_grant", 32'(gid), 32'd0);
        bus.req_valid = '0;

        // Random traffic with random backpressure.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    set_req(i, ra, rb, 1'($urandom));
                end
            end
            if (bus.req_valid == '0) set_req(int'($urandom_range(0, NREQ - 1)),
                                             16'($urandom), 16'($urandom), 1'($urandom));
            serve(int'($urandom_range(0, 3)), gid, s, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p4_adder_arbiter.md
# p4_adder_arbiter

Round-robin scheduler that shares a single combinational P4 adder among NREQ requesters. Each requester presents operands through a valid/ready request channel; the block grants one requester at a time and drives the adder from registered operands. It captures the sum and carry, then returns the result on one shared response channel tagged with the requester index. It sits between the client units and the P4 wrapper instance.

## Interface
- NBIT, 16, operand/sum width (matches adder)
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), localparam, response tag width
- clock  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  request accepted (one-hot or zero)
- req_a  in  NREQ*NBIT  operand A, requester i at [i*NBIT +: NBIT]
- req_b  in  NREQ*NBIT  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that owns result
- rsp_s  out  NBIT  sum
- rsp_cout  out  1  carry-out
- add_a, add_b  out  NBIT  adder operands (to A, B)
- add_cin  out  1  adder carry-in (to cin)
- add_s  in  NBIT  adder sum (from S)
- add_cout  in  1  adder carry-out (from cout)

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE: if any req_valid is set, grant g is the first set bit at or after rr_ptr, searching upward modulo NREQ. req_ready[g]=1 combinationally in the same cycle. On that edge: latch req_a/req_b/req_cin of g into operand regs, id_q<=g, rr_ptr<=(g+1) mod NREQ, go to CALC. If no requester is valid, stay in IDLE and leave rr_ptr unchanged.
- CALC: add_* are driven from the operand regs, which are stable for the whole cycle. On the edge: rsp_s<=add_s, rsp_cout<=add_cout, go to RESP.
- RESP: rsp_valid=1. If rsp_ready, go to IDLE on the edge. Otherwise hold the state; all outputs are stable.
- req_ready is all-zero outside IDLE, so no request is accepted while a result is pending.
- Arithmetic: {rsp_cout,rsp_s} = A+B+cin computed by the adder. The block performs no arithmetic itself.
- add_a/add_b/add_cin always reflect the operand regs and keep their value after CALC.
- A requester that drops req_valid before being granted is never served. Requesters are expected to hold valid and operands until ready.

## Timing
- Reset values: state=IDLE, rr_ptr=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, add_*=0, req_ready=0 while rst_n is low.
- Latency: accept at edge t, rsp_valid high in the cycle after edge t+1 (2 cycles). Minimum initiation interval is 3 cycles with rsp_ready tied high.
- The adder path (operand regs -> add_* -> add_s -> rsp_s) must close within one clock period.
- Reset mid-operation (in CALC or RESP): the transaction is discarded, no response is produced, and rr_ptr returns to 0.
- Simultaneous requests: exactly one grant per IDLE cycle. Under sustained all-valid load the grant order is 0,1,...,NREQ-1,0 (pointer wraps).
- Backpressure: rsp_ready low for k cycles extends RESP by k cycles. rsp_* must not change during the stall.

## Structure
- Package p4_arb_pkg: state_t enum {IDLE,CALC,RESP}. Shared with bench for FSM coverage.
- Sub-module rr_arbiter #(NREQ): combinational. Inputs are req vector and ptr; outputs are one-hot grant, grant index and any_req. It is reused for other shared datapath units.
- Top module instantiates rr_arbiter, the FSM and the registers. The P4 wrapper is instantiated outside this block and connected via add_*.

## Test plan
- Single request, NBIT=16: requester 2 sends A=0x1234, B=0x0001, cin=1 -> rsp_valid 2 cycles after accept, rsp_id=2, rsp_s=0x1236, rsp_cout=0.
- Overflow: A=0xFFFF, B=0x0001, cin=0 -> rsp_s=0x0000, rsp_cout=1. Also A=0xFFFF, B=0xFFFF, cin=1 -> rsp_s=0xFFFF, rsp_cout=1.
- All 4 requesters continuously valid with rsp_ready=1 -> responses in id order 0,1,2,3,0,1, and exactly one req_ready bit per accept.
- rsp_ready held low for 5 cycles in RESP -> rsp_* constant, req_ready=0 throughout, and the next grant occurs only after the handshake.
- rst_n asserted during CALC -> all outputs return to reset values immediately. After release, a request from requester 0 is granted first (rr_ptr=0).
- Only requester 3 valid while rr_ptr=1 -> grant 3 and rr_ptr becomes 0 (wrap).
